// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: Avalon-MM slave that fades the two 8-bit PWM duty values
// toward software-written targets, one step per prescaler tick.
// Optional feature macro: PWM_RAMP_IRQ_EN adds the irq output, the irq enable at
// CTRL bit2 and the IRQ_CLR register at address 5.
module pwm_ramp_sequencer #(
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd49999,
    parameter logic [7:0]  RESET_DUTY       = 8'd0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [7:0]  value1,
    output logic [7:0]  value2,
    output logic        busy,
    output logic        done_pulse
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} chanState_t;

    chanState_t       state_q [2];
    chanState_t       state_d [2];
    logic [1:0][7:0]  value_q, value_d;
    logic [1:0][7:0]  target_q, target_d;
    logic [15:0]      prescale_q, prescale_d;
    logic [15:0]      count_q, count_d;
    logic             enable_q, enable_d;
    logic             donePulse_q, donePulse_d;
    logic             irqPending_q, irqPending_d;
    logic [31:0]      readData_q, readData_d;
    logic [1:0]       busyVec;
    logic [1:0]       complete;
    logic [1:0]       wrTarget;
    logic             wrPrescale, wrCtrl, wrCur, abortReq, irqClear, tick;
    logic             unusedBits;
`ifdef PWM_RAMP_IRQ_EN
    logic             irqEnable_q, irqEnable_d;
`endif

    assign wrTarget[0] = avs_write && (avs_address == 3'd0);
    assign wrTarget[1] = avs_write && (avs_address == 3'd1);
    assign wrPrescale  = avs_write && (avs_address == 3'd2);
    assign wrCtrl      = avs_write && (avs_address == 3'd3);
    assign wrCur       = avs_write && (avs_address == 3'd4);
    assign abortReq    = wrCtrl && avs_writedata[1];
    assign tick        = enable_q && (count_q == prescale_q);
    assign unusedBits  = &{1'b0, avs_writedata[31:16]};

`ifdef PWM_RAMP_IRQ_EN
    assign irqClear    = avs_write && (avs_address == 3'd5) && avs_writedata[0];
    assign irqEnable_d = wrCtrl ? avs_writedata[2] : irqEnable_q;
    assign irq         = irqPending_q && irqEnable_q;
`else
    assign irqClear    = wrCtrl && avs_writedata[3];
`endif

    assign busyVec[0]   = (state_q[0] != IDLE);
    assign busyVec[1]   = (state_q[1] != IDLE);
    assign busy         = |busyVec;
    assign value1       = value_q[0];
    assign value2       = value_q[1];
    assign done_pulse   = donePulse_q;
    assign avs_readdata = readData_q;

    // Prescaler: free-runs only while enabled, wraps at PRESCALE, cleared by a PRESCALE write.
    always_comb begin
        count_d    = count_q;
        prescale_d = prescale_q;
        enable_d   = enable_q;
        if (wrPrescale) begin
            prescale_d = avs_writedata[15:0];
            count_d    = 16'd0;
        end else if (enable_q) begin
            count_d = tick ? 16'd0 : count_q + 16'd1;
        end
        if (wrCtrl) begin
            enable_d = avs_writedata[0];
        end
    end

    // Channel FSMs: CUR write beats abort, abort beats tick, a target write suppresses that channel's step.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            value_d[c]  = value_q[c];
            target_d[c] = target_q[c];
            state_d[c]  = state_q[c];
            complete[c] = 1'b0;
            if (wrCur) begin
                value_d[c]  = avs_writedata[8*c +: 8];
                target_d[c] = avs_writedata[8*c +: 8];
                state_d[c]  = IDLE;
            end else if (abortReq) begin
                target_d[c] = value_q[c];
                state_d[c]  = IDLE;
            end else begin
                if (wrTarget[c]) begin
                    target_d[c] = avs_writedata[7:0];
                end
                case (state_q[c])
                    IDLE: begin
                        if (value_q[c] < target_q[c]) begin
                            state_d[c] = UP;
                        end else if (value_q[c] > target_q[c]) begin
                            state_d[c] = DOWN;
                        end
                    end
                    UP: begin
                        if (value_q[c] >= target_q[c]) begin
                            state_d[c] = (value_q[c] > target_q[c]) ? DOWN : IDLE;
                        end else if (tick && !wrTarget[c]) begin
                            value_d[c] = value_q[c] + 8'd1;
                            if (value_q[c] + 8'd1 == target_q[c]) begin
                                state_d[c]  = IDLE;
                                complete[c] = 1'b1;
                            end
                        end
                    end
                    DOWN: begin
                        if (value_q[c] <= target_q[c]) begin
                            state_d[c] = (value_q[c] < target_q[c]) ? UP : IDLE;
                        end else if (tick && !wrTarget[c]) begin
                            value_d[c] = value_q[c] - 8'd1;
                            if (value_q[c] - 8'd1 == target_q[c]) begin
                                state_d[c]  = IDLE;
                                complete[c] = 1'b1;
                            end
                        end
                    end
                    default: state_d[c] = IDLE;
                endcase
            end
        end
    end

    // Completion pulse and sticky interrupt flag; a new completion wins over a clear.
    always_comb begin
        donePulse_d  = |complete;
        irqPending_d = irqPending_q;
        if (donePulse_q) begin
            irqPending_d = 1'b1;
        end else if (irqClear) begin
            irqPending_d = 1'b0;
        end
    end

    // Read mux: sampled from current register state, held between reads.
    always_comb begin
        readData_d = readData_q;
        if (avs_read) begin
            case (avs_address)
                3'd0:    readData_d = {24'd0, target_q[0]};
                3'd1:    readData_d = {24'd0, target_q[1]};
                3'd2:    readData_d = {16'd0, prescale_q};
`ifdef PWM_RAMP_IRQ_EN
                3'd3:    readData_d = {28'd0, irqPending_q, irqEnable_q, busyVec[0], enable_q};
`else
                3'd3:    readData_d = {28'd0, irqPending_q, busyVec[1], busyVec[0], enable_q};
`endif
                3'd4:    readData_d = {16'd0, value_q[1], value_q[0]};
                default: readData_d = 32'd0;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            value_q      <= {2{RESET_DUTY}};
            target_q     <= {2{RESET_DUTY}};
            state_q[0]   <= IDLE;
            state_q[1]   <= IDLE;
            prescale_q   <= DEFAULT_PRESCALE;
            count_q      <= 16'd0;
            enable_q     <= 1'b0;
            donePulse_q  <= 1'b0;
            irqPending_q <= 1'b0;
            readData_q   <= 32'd0;
`ifdef PWM_RAMP_IRQ_EN
            irqEnable_q  <= 1'b0;
`endif
        end else begin
            value_q      <= value_d;
            target_q     <= target_d;
            state_q[0]   <= state_d[0];
            state_q[1]   <= state_d[1];
            prescale_q   <= prescale_d;
            count_q      <= count_d;
            enable_q     <= enable_d;
            donePulse_q  <= donePulse_d;
            irqPending_q <= irqPending_d;
            readData_q   <= readData_d;
`ifdef PWM_RAMP_IRQ_EN
            irqEnable_q  <= irqEnable_d;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb_pwm_ramp_sequencer: directed test of the two-channel PWM ramp sequencer.
module tb_pwm_ramp_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [7:0]  value1;
    logic [7:0]  value2;
    logic        busy;
    logic        done_pulse;
`ifdef PWM_RAMP_IRQ_EN
    logic        irq;
`endif

    int totalChecks = 0;
    int badChecks   = 0;

    pwm_ramp_sequencer dut (
        .CLK           (CLK),
        .RST           (RST),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .value1        (value1),
        .value2        (value2),
        .busy          (busy),
        .done_pulse    (done_pulse)
`ifdef PWM_RAMP_IRQ_EN
        ,
        .irq           (irq)
`endif
    );

    // 100 MHz-style free-running clock.
    always #5 CLK = ~CLK;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n clock edges, ending 1 time unit after the last edge.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Single-cycle register write.
    task automatic writeReg(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        waitCycles(1);
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
    endtask

    // Single-cycle register read; data is valid right after the edge.
    task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        waitCycles(1);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    // Bounded wait for channel 1 to hit a value; returns edges consumed.
    task automatic waitValue1(input logic [7:0] want, input int budget, output int cycles);
        cycles = 0;
        while (value1 !== want && cycles < budget) begin
            waitCycles(1);
            cycles++;
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          n;

        RST = 1'b1; avs_address = 3'd0; avs_write = 1'b0; avs_writedata = 32'd0; avs_read = 1'b0;
        waitCycles(3);
        RST = 1'b0;

        // Reset state
        checkOutput("rst_value1", {24'd0, value1}, 32'd0);
        checkOutput("rst_value2", {24'd0, value2}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done_pulse}, 32'd0);
        checkOutput("rst_readdata", avs_readdata, 32'd0);
        readReg(3'd2, rd);
        checkOutput("rst_prescale", rd, 32'h0000C34F);
        readReg(3'd6, rd);
        checkOutput("unused_reg6", rd, 32'd0);

        // Up ramp: prescale 3, target 5
        writeReg(3'd2, 32'd3);
        writeReg(3'd0, 32'd5);
        writeReg(3'd3, 32'd1);
        checkOutput("up_busy", {31'd0, busy}, 32'd1);
        waitCycles(3);
        checkOutput("up_before_tick", {24'd0, value1}, 32'd0);
        waitCycles(1);
        checkOutput("up_v1", {24'd0, value1}, 32'd1);
        waitCycles(4);
        checkOutput("up_v2", {24'd0, value1}, 32'd2);
        checkOutput("up_no_done", {31'd0, done_pulse}, 32'd0);
        waitCycles(8);
        checkOutput("up_v4", {24'd0, value1}, 32'd4);
        waitCycles(4);
        checkOutput("up_v5", {24'd0, value1}, 32'd5);
        checkOutput("up_done", {31'd0, done_pulse}, 32'd1);
        waitCycles(1);
        checkOutput("up_done_drop", {31'd0, done_pulse}, 32'd0);
        checkOutput("up_busy_drop", {31'd0, busy}, 32'd0);
        checkOutput("up_v2_idle", {24'd0, value2}, 32'd0);
        readReg(3'd3, rd);
        checkOutput("ctrl_irq_set", rd & 32'hB, 32'h9);
        writeReg(3'd3, 32'h9);
        readReg(3'd3, rd);
        checkOutput("ctrl_irq_clr", rd & 32'hB, 32'h1);

        // Reversal: 10 -> 20, retarget to 12 at 15
        writeReg(3'd4, 32'h0000000A);
        writeReg(3'd2, 32'd3);
        writeReg(3'd0, 32'd20);
        waitValue1(8'd15, 100, n);
        checkOutput("rev_reach15", {24'd0, value1}, 32'd15);
        writeReg(3'd1, 32'h80);
        writeReg(3'd0, 32'd12);
        waitCycles(2);
        checkOutput("rev_v14", {24'd0, value1}, 32'd14);
        checkOutput("rev_ch2_1", {24'd0, value2}, 32'd1);
        waitCycles(4);
        checkOutput("rev_v13", {24'd0, value1}, 32'd13);
        waitCycles(4);
        checkOutput("rev_v12", {24'd0, value1}, 32'd12);
        checkOutput("rev_ch2_3", {24'd0, value2}, 32'd3);
        checkOutput("rev_done", {31'd0, done_pulse}, 32'd1);
        checkOutput("rev_busy_ch2", {31'd0, busy}, 32'd1);

        // Collision: target write coincident with a tick
        writeReg(3'd0, 32'd40);
        waitCycles(3);
        checkOutput("col_pre_v1", {24'd0, value1}, 32'd13);
        checkOutput("col_pre_v2", {24'd0, value2}, 32'd4);
        waitCycles(3);
        writeReg(3'd0, 32'd40);
        checkOutput("col_v1_hold", {24'd0, value1}, 32'd13);
        checkOutput("col_v2_step", {24'd0, value2}, 32'd5);
        waitCycles(4);
        checkOutput("col_post_v1", {24'd0, value1}, 32'd14);
        checkOutput("col_post_v2", {24'd0, value2}, 32'd6);

        // Abort at 7, then CUR jump
        writeReg(3'd4, 32'h00000005);
        writeReg(3'd2, 32'd3);
        writeReg(3'd0, 32'd20);
        waitValue1(8'd7, 100, n);
        checkOutput("abt_reach7", {24'd0, value1}, 32'd7);
        writeReg(3'd3, 32'h3);
        checkOutput("abt_v1", {24'd0, value1}, 32'd7);
        checkOutput("abt_busy", {31'd0, busy}, 32'd0);
        checkOutput("abt_no_done", {31'd0, done_pulse}, 32'd0);
        readReg(3'd0, rd);
        checkOutput("abt_target1", rd, 32'd7);
        waitCycles(8);
        checkOutput("abt_frozen", {24'd0, value1}, 32'd7);
        writeReg(3'd4, 32'h00004020);
        checkOutput("cur_v1", {24'd0, value1}, 32'h20);
        checkOutput("cur_v2", {24'd0, value2}, 32'h40);
        checkOutput("cur_busy", {31'd0, busy}, 32'd0);
        readReg(3'd4, rd);
        checkOutput("cur_read", rd, 32'h00004020);

        // PRESCALE = 0 full-scale ramp, no wrap
        writeReg(3'd4, 32'd0);
        writeReg(3'd2, 32'd0);
        writeReg(3'd0, 32'd255);
        waitValue1(8'd255, 400, n);
        checkOutput("full_cycles", n, 32'd256);
        checkOutput("full_done", {31'd0, done_pulse}, 32'd1);
        waitCycles(5);
        checkOutput("full_nowrap", {24'd0, value1}, 32'd255);
        checkOutput("full_idle", {31'd0, busy}, 32'd0);

        // Disable at 100, hold 50 cycles, resume at 101
        writeReg(3'd4, 32'd0);
        writeReg(3'd0, 32'd200);
        waitValue1(8'd99, 200, n);
        checkOutput("dis_reach99", {24'd0, value1}, 32'd99);
        writeReg(3'd3, 32'd0);
        checkOutput("dis_v100", {24'd0, value1}, 32'd100);
        waitCycles(50);
        checkOutput("dis_hold", {24'd0, value1}, 32'd100);
        checkOutput("dis_busy", {31'd0, busy}, 32'd1);
        writeReg(3'd3, 32'd1);
        checkOutput("dis_reenable", {24'd0, value1}, 32'd100);
        waitCycles(1);
        checkOutput("dis_resume", {24'd0, value1}, 32'd101);

        // Reset mid-ramp
        RST = 1'b1;
        waitCycles(1);
        RST = 1'b0;
        checkOutput("rst2_value1", {24'd0, value1}, 32'd0);
        checkOutput("rst2_busy", {31'd0, busy}, 32'd0);
        readReg(3'd2, rd);
        checkOutput("rst2_prescale", rd, 32'h0000C34F);
        readReg(3'd0, rd);
        checkOutput("rst2_target1", rd, 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
